// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_responder_pkg
// Shared types and constants for the data-memory responder.
//   dmem_state_e : responder FSM states (IDLE, WAIT, RESP)
//   dmem_req_t   : one request as seen on the request channel
//   dmem_rsp_t   : one response as driven on the response channel
//   LAT_CNT_W    : width of the latency counter (RD_LATENCY up to 15)
// The struct fields are sized for the widest configuration supported
// (64-bit data, 64-bit address); narrower builds zero-extend into them.
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

    localparam int LAT_CNT_W   = 4;
    localparam int DMEM_MAX_DW = 64;
    localparam int DMEM_MAX_AW = 64;
    localparam int DMEM_MAX_NB = DMEM_MAX_DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_MAX_AW-1:0] addr;
        logic [DMEM_MAX_DW-1:0] wdata;
        logic [DMEM_MAX_NB-1:0] mask;
    } dmem_req_t;

    typedef struct packed {
        logic [DMEM_MAX_DW-1:0] rdata;
        logic                   err;
    } dmem_rsp_t;

endpackage

// File: rtl/dmem_resp_array.sv
// ---------------------------------------------------------------------------
// dmem_resp_array
// Single-port synchronous RAM with byte-lane write enables and a registered
// read port. Contents are never reset.
//   clk   : clock, rising edge
//   we    : per-byte-lane write enables (DATA_WIDTH/8 bits)
//   addr  : word index
//   wdata : write data, lane-aligned
//   re    : read enable; loads rdata from mem[addr] on the clock edge
//   rdata : registered read data, holds its value while re is low
// ---------------------------------------------------------------------------
module dmem_resp_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                       clk,
    input  logic [DATA_WIDTH/8-1:0]    we,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic                       re,
    output logic [DATA_WIDTH-1:0]      rdata
);

    localparam int NB = DATA_WIDTH / 8;

    // One independent byte-wide array per lane so every lane has exactly one
    // writer and maps cleanly onto byte-enabled block RAM.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : gen_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_reg;

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    lane_mem[addr] <= wdata[gi*8 +: 8];
                end
                if (re) begin
                    lane_rd_reg <= lane_mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = lane_rd_reg;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for the memory-stage data port. Accepts one request
// at a time (valid/ready), commits byte-masked writes on the accept edge,
// and returns a response RD_LATENCY edges after accept (the accept edge
// counts as the first), held until the requester takes it.
//
// Ports:
//   clk, arst            : clock (rising edge), async active-high reset
//   req_valid/req_ready  : request handshake
//   req_we               : 1 = write, 0 = read
//   req_addr             : byte address (offset bits ignored, wraps mod DEPTH)
//   req_wdata, req_mask  : store data and byte-lane enables (writes only)
//   rsp_valid/rsp_ready  : response handshake
//   rsp_rdata            : read data; 0 for write responses and when idle
//   rsp_err              : error flag
//
// Build option: define DMEM_RESP_ERR_EN to flag out-of-range or misaligned
// requests with rsp_err = 1 (no array write, rdata 0). Without it rsp_err is
// 0 and addresses simply wrap.
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int DMEM_SZ_IN_KB = 1,
    parameter int RD_LATENCY    = 2
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_mask,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err
);

    localparam int NB       = DATA_WIDTH / 8;
    localparam int DEPTH    = DMEM_SZ_IN_KB * 1024 / NB;
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int OFF_W    = $clog2(NB);
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LATENCY - 1);

    dmem_state_e          state_reg;
    logic                 req_ready_reg;
    logic                 rsp_valid_reg;
    logic                 rsp_err_reg;
    logic [LAT_CNT_W-1:0] cnt_reg;
    logic                 we_reg;
    logic                 err_reg;
    logic [IDX_W-1:0]     idx_reg;

    dmem_req_t            req_bus;
    dmem_rsp_t            rsp_bus;
    logic [IDX_W-1:0]     req_idx;
    logic                 req_err;
    logic                 accept;
    logic                 enter_resp;
    logic [NB-1:0]        ram_we;
    logic [IDX_W-1:0]     ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    always_comb begin
        req_bus       = '0;
        req_bus.we    = req_we;
        req_bus.addr  = DMEM_MAX_AW'(req_addr);
        req_bus.wdata = DMEM_MAX_DW'(req_wdata);
        req_bus.mask  = DMEM_MAX_NB'(req_mask);
    end

    assign req_idx = req_bus.addr[IDX_W+OFF_W-1:OFF_W];

`ifdef DMEM_RESP_ERR_EN
    localparam longint SZ_BYTES = longint'(DMEM_SZ_IN_KB) * 1024;
    assign req_err = (longint'(req_addr) >= SZ_BYTES) ||
                     (req_bus.addr[OFF_W-1:0] != '0);
`else
    assign req_err = 1'b0;
`endif

    assign accept = req_ready_reg && req_valid;

    // The read word is captured in the RAM output register on the edge that
    // enters RESP, so it sees every write committed before that edge.
    assign enter_resp = (accept && (LAT_LOAD == '0)) ||
                        ((state_reg == WAIT) && (cnt_reg == LAT_CNT_W'(1)));

    // Writes commit on the accept edge itself; flagged requests never write.
    assign ram_we   = (accept && req_we && !req_err) ? req_bus.mask[NB-1:0] : '0;
    // In IDLE the address comes straight from the request so that a write
    // (or a latency-1 read) can use it on the accept edge.
    assign ram_addr = (state_reg == IDLE) ? req_idx : idx_reg;

    dmem_resp_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (req_bus.wdata[DATA_WIDTH-1:0]),
        .re    (enter_resp),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_reg     <= IDLE;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            cnt_reg       <= '0;
            we_reg        <= 1'b0;
            err_reg       <= 1'b0;
            idx_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg        <= req_we;
                        err_reg       <= req_err;
                        idx_reg       <= req_idx;
                        cnt_reg       <= LAT_LOAD;
                        req_ready_reg <= 1'b0;
                        if (LAT_LOAD == '0) begin
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= req_err;
                        end else begin
                            state_reg     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - LAT_CNT_W'(1);
                    if (cnt_reg == LAT_CNT_W'(1)) begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= err_reg;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        rsp_err_reg   <= 1'b0;
                        req_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                    rsp_valid_reg <= 1'b0;
                    rsp_err_reg   <= 1'b0;
                end
            endcase
        end
    end

    // The RAM output register is not reset, so read data is gated by the
    // (reset) response state: zero whenever no read response is presented.
    always_comb begin
        rsp_bus     = '0;
        rsp_bus.err = rsp_err_reg;
        if (rsp_valid_reg && !we_reg && !err_reg) begin
            rsp_bus.rdata = DMEM_MAX_DW'(ram_rdata);
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_bus.rdata[DATA_WIDTH-1:0];
    assign rsp_err   = rsp_bus.err;

    // Padding bits of the shared structs are intentionally not consumed.
    logic unused_bits;
    assign unused_bits = ^{req_bus, rsp_bus};

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder (default parameters, RD_LATENCY = 2).
// A transaction-level model predicts ready/valid/data/err every cycle; a
// compare process checks them on each falling edge, and the directed tests
// add literal expectations for data values and response latency.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int KB    = 1;
    localparam int L     = 2;
    localparam int DEPTH = KB * 1024 / 4;

    logic          clk = 1'b0;
    logic          arst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_mask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    always #5 clk = ~clk;

    dmem_responder #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .DMEM_SZ_IN_KB (KB),
        .RD_LATENCY    (L)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_mask  (req_mask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [31:0] mmem [DEPTH];
    bit          m_busy = 1'b0;   // a transaction has been accepted, not yet retired
    bit          m_have = 1'b0;   // its response is due and presented
    int          cyc    = 0;
    int          m_due  = 0;
    logic [31:0] m_rdata = '0;
    bit          m_err  = 1'b0;
    int          m_idx;
    bit          m_bad;

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            m_busy = 1'b0;
            m_have = 1'b0;
        end else begin
            cyc++;
            if (m_busy && m_have && rsp_ready) begin
                m_busy = 1'b0;
                m_have = 1'b0;
            end else if (!m_busy && req_valid) begin
                m_idx = int'(req_addr[9:2]);
`ifdef DMEM_RESP_ERR_EN
                m_bad = (req_addr >= 32'(KB * 1024)) || (req_addr[1:0] != 2'b00);
`else
                m_bad = 1'b0;
`endif
                if (req_we && !m_bad) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req_mask[b]) mmem[m_idx][b*8 +: 8] = req_wdata[b*8 +: 8];
                    end
                end
                m_rdata = (req_we || m_bad) ? 32'h0 : mmem[m_idx];
                m_err   = m_bad;
                m_busy  = 1'b1;
                m_due   = cyc + L - 1;   // accept edge counts as edge 1 of L
            end
            if (m_busy && !m_have && cyc >= m_due) m_have = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_req_ready", 32'(req_ready), 32'(!m_busy));
            check("cyc_rsp_valid", 32'(rsp_valid), 32'(m_have));
            check("cyc_rsp_rdata", rsp_rdata, m_have ? m_rdata : 32'h0);
            check("cyc_rsp_err",   32'(rsp_err), m_have ? 32'(m_err) : 32'h0);
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] mask, input int hold,
                          output logic [31:0] rd, output logic er, output int lat);
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_mask  = mask;
        rsp_ready = (hold == 0);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_accept", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rd = rsp_rdata;
        er = rsp_err;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          guard;

    initial begin
        arst      = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_mask  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        arst   = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'h1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);

        // Full write then read back, with latency pinned.
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, rd, er, lat);
        $display("write addr=00000010 data=deadbeef mask=f lat=%0d rdata=%h", lat, rd);
        check("wr_latency", 32'(lat), 32'(L));
        check("wr_rdata_zero", rd, 32'h0);
        do_req(1'b0, 32'h10, 32'h0, 4'b0000, 0, rd, er, lat);
        $display("read  addr=00000010 lat=%0d rdata=%h err=%0d", lat, rd, er);
        check("rd_full_data", rd, 32'hDEADBEEF);
        check("rd_latency", 32'(lat), 32'(L));
        check("rd_err", 32'(er), 32'h0);

        // Partial write of lane 0.
        do_req(1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, rd, er, lat);
        $display("write addr=00000010 data=000000aa mask=1 lat=%0d", lat);
        do_req(1'b0, 32'h10, 32'h0, 4'b0000, 0, rd, er, lat);
        $display("read  addr=00000010 lat=%0d rdata=%h", lat, rd);
        check("rd_partial_data", rd, 32'hDEADBEAA);

        // Backpressure with a competing request queued behind the response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
        req_wdata = 32'h5555AAAA; req_mask = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            check("bp_rsp_rdata", rsp_rdata, 32'hDEADBEAA);
            check("bp_req_ready", 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);              // response handshake edge
        @(negedge clk);
        check("bp_ready_after_hs", 32'(req_ready), 32'h1);
        check("bp_valid_after_hs", 32'(rsp_valid), 32'h0);
        @(posedge clk);              // queued write accepted here
        #1 req_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("bp_queued_rsp_seen", 32'(rsp_valid), 32'h1);
        $display("backpressure read 00000010 held 5 cycles; queued write 00000020 answered");
        @(posedge clk);

        // Reset while a read of 0x20 is in WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 arst = 1'b1;
        #1;
        check("midop_rst_ready", 32'(req_ready), 32'h1);
        check("midop_rst_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        arst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midop_no_rsp", 32'(rsp_valid), 32'h0);
        end
        do_req(1'b0, 32'h20, 32'h0, 4'b0000, 0, rd, er, lat);
        $display("read  addr=00000020 after reset lat=%0d rdata=%h", lat, rd);
        check("midop_data_kept", rd, 32'h5555AAAA);

        // Asynchronous reset while a read response is presented.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("resp_before_rst", rsp_rdata, 32'hDEADBEAA);
        #1 arst = 1'b1;
        #1;
        check("async_rst_ready", 32'(req_ready), 32'h1);
        check("async_rst_valid", 32'(rsp_valid), 32'h0);
        check("async_rst_rdata", rsp_rdata, 32'h0);
        $display("async reset during RESP: ready=%0d valid=%0d rdata=%h", req_ready, rsp_valid, rsp_rdata);
        @(negedge clk);
        arst = 1'b0;
        rsp_ready = 1'b1;

        // Mask-0 write still responds and leaves data unchanged.
        do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, rd, er, lat);
        $display("write addr=00000010 mask=0 lat=%0d", lat);
        check("mask0_latency", 32'(lat), 32'(L));
        do_req(1'b0, 32'h10, 32'h0, 4'b0000, 2, rd, er, lat);
        $display("read  addr=00000010 lat=%0d rdata=%h", lat, rd);
        check("mask0_data", rd, 32'hDEADBEAA);

        // Out-of-range / misaligned addresses.
        do_req(1'b1, 32'h0, 32'hCAFEF00D, 4'b1111, 0, rd, er, lat);
        do_req(1'b1, 32'h400, 32'h12345678, 4'b1111, 0, rd, er, lat);
        $display("write addr=00000400 data=12345678 err=%0d", er);
`ifdef DMEM_RESP_ERR_EN
        check("oor_wr_err", 32'(er), 32'h1);
`else
        check("oor_wr_err", 32'(er), 32'h0);
`endif
        do_req(1'b0, 32'h0, 32'h0, 4'b0000, 0, rd, er, lat);
        $display("read  addr=00000000 rdata=%h err=%0d", rd, er);
`ifdef DMEM_RESP_ERR_EN
        check("alias_rd_data", rd, 32'hCAFEF00D);
`else
        check("alias_rd_data", rd, 32'h12345678);
`endif
        do_req(1'b0, 32'h13, 32'h0, 4'b0000, 0, rd, er, lat);
        $display("read  addr=00000013 rdata=%h err=%0d", rd, er);
`ifdef DMEM_RESP_ERR_EN
        check("misalign_rd_data", rd, 32'h0);
        check("misalign_rd_err", 32'(er), 32'h1);
`else
        check("misalign_rd_data", rd, 32'hDEADBEAA);
        check("misalign_rd_err", 32'(er), 32'h0);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
